// File: rtl/lut_multiplier_pkg.sv
// Shared types and helpers for the table-lookup multiplier.
// Holds the fill FSM state encoding and the table-depth helper.
package lut_multiplier_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int depth(input int w);
    return 1 << (2 * w);
  endfunction

endpackage

// File: rtl/lut_mult_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port with enable.
// Neither the array nor the read register is reset; the fill FSM rewrites every entry.
module lut_mult_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lut_multiplier.sv
// Table-lookup multiplier: builds an a*b table with adds after reset, then serves
// streaming valid/ready lookups with a 2-cycle latency and full back-pressure.
module lut_multiplier
  import lut_multiplier_pkg::*;
#(
  parameter int W      = 3,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reinit,
  output logic          init_done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*W-1:0] result
);

  localparam int            AW        = 2 * W;
  localparam int            DEPTH     = depth(W);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [W-1:0]  MIN_B     = {1'b1, {(W-1){1'b0}}};

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   acc_fill;
  logic [AW-1:0]   nxt_addr;
  logic [W-1:0]    nxt_ai;
  logic [W-1:0]    nxt_bi;
  logic [AW-1:0]   ai_ext;
  logic            we;
  logic            re;
  logic            en;
  logic            accept;
  logic            s1_valid;
  logic [AW-1:0]   rd_data;

  // Accumulator value for the entry after addr_q; rows restart at b=0 and the
  // signed most-negative column is seeded directly since it cannot be reached by adding.
  always_comb begin
    nxt_addr = addr_q + AW'(1);
    nxt_ai   = nxt_addr[AW-1:W];
    nxt_bi   = nxt_addr[W-1:0];
    if (SIGNED != 0) begin
      ai_ext = {{W{nxt_ai[W-1]}}, nxt_ai};
    end else begin
      ai_ext = {{W{1'b0}}, nxt_ai};
    end
    if (nxt_bi == '0) begin
      acc_fill = '0;
    end else if ((SIGNED != 0) && (nxt_bi == MIN_B)) begin
      acc_fill = AW'(0) - (ai_ext << (W - 1));
    end else begin
      acc_fill = acc_q + ai_ext;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    we      = 1'b0;
    case (state_q)
      INIT: begin
        if (reinit) begin
          addr_d = '0;
          acc_d  = '0;
        end else begin
          we     = 1'b1;
          addr_d = nxt_addr;
          acc_d  = acc_fill;
          if (addr_q == LAST_ADDR) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (reinit) begin
          state_d = INIT;
          addr_d  = '0;
          acc_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        addr_d  = '0;
        acc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      addr_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
    end
  end

  assign en        = !(out_valid && !out_ready);
  assign init_done = (state_q == RUN);
  assign in_ready  = (state_q == RUN) && en;
  assign accept    = in_valid && in_ready;
  assign re        = en && (state_q == RUN);

  // Both stages advance together; a stalled output freezes the RAM read register too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (reinit) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= accept;
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= rd_data;
      end
    end
  end

  lut_mult_ram #(
    .ADDR_W(AW),
    .DATA_W(AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (addr_q),
    .wdata (acc_q),
    .re    (re),
    .raddr ({a, b}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_lut_multiplier.sv
// Scoreboard bench for lut_multiplier: an unsigned and a signed instance share stimulus,
// each checked against plain-arithmetic products queued at request acceptance.
module tb_lut_multiplier;

  localparam int W     = 3;
  localparam int AW    = 2 * W;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          reinit;
  logic          in_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_ready;

  logic          init_done_u, in_ready_u, out_valid_u;
  logic [AW-1:0] result_u;
  logic          init_done_s, in_ready_s, out_valid_s;
  logic [AW-1:0] result_s;

  int n_pass  = 0;
  int n_total = 0;
  int exp_u[$];
  int exp_s[$];
  int cyc = 0;
  bit rnd_bp = 0;
  bit gap_mode = 0;
  int first_out = -1;
  int last_out = -1;
  int n_out = 0;

  lut_multiplier #(.W(W), .SIGNED(0)) u_dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .reinit    (reinit),
    .init_done (init_done_u),
    .in_valid  (in_valid),
    .in_ready  (in_ready_u),
    .a         (a),
    .b         (b),
    .out_valid (out_valid_u),
    .out_ready (out_ready),
    .result    (result_u)
  );

  lut_multiplier #(.W(W), .SIGNED(1)) u_dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .reinit    (reinit),
    .init_done (init_done_s),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .a         (a),
    .b         (b),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .result    (result_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int modelU(input int x, input int y);
    return (x * y) % DEPTH;
  endfunction

  function automatic int modelS(input int x, input int y);
    int sx;
    int sy;
    sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
    return ((sx * sy) % DEPTH + DEPTH) % DEPTH;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitors: compare the presented result to the oldest expectation each
  // cycle it is valid, and retire it only when the consumer accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_u) begin
        checkOutput("sb_u_pending", int'(exp_u.size() > 0), 1);
        if (exp_u.size() > 0) begin
          checkOutput("sb_u_result", int'(result_u), exp_u[0]);
          if (out_ready) void'(exp_u.pop_front());
        end
      end
      if (in_valid && in_ready_u) exp_u.push_back(modelU(int'(a), int'(b)));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_s) begin
        checkOutput("sb_s_pending", int'(exp_s.size() > 0), 1);
        if (exp_s.size() > 0) begin
          checkOutput("sb_s_result", int'(result_s), exp_s[0]);
          if (out_ready) void'(exp_s.pop_front());
        end
      end
      if (in_valid && in_ready_s) exp_s.push_back(modelS(int'(a), int'(b)));
    end
  end

  always @(negedge clk) begin
    if (gap_mode && out_valid_u && out_ready) begin
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      n_out++;
    end
  end

  always begin
    @(posedge clk);
    if (rnd_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offers one request starting at posedge+1 and returns at posedge+1 after it is taken.
  task automatic applyStimulus(input int x, input int y);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    a = W'(x);
    b = W'(y);
    forever begin
      @(negedge clk);
      if (in_ready_u) break;
      waited++;
      if (waited > 100) begin
        checkOutput("accept_timeout", waited, 0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitInit(input string tag);
    int n;
    int rise_u;
    int rise_s;
    int early;
    n = 0;
    rise_u = -1;
    rise_s = -1;
    early = 0;
    while ((rise_u < 0 || rise_s < 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done_u && rise_u < 0) rise_u = n;
      if (init_done_s && rise_s < 0) rise_s = n;
      if (!init_done_u && in_ready_u) early++;
    end
    checkOutput({tag, "_latency_u"}, rise_u, DEPTH);
    checkOutput({tag, "_latency_s"}, rise_s, DEPTH);
    checkOutput({tag, "_early_ready"}, early, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_init_done"}, int'(init_done_u), 0);
    checkOutput({tag, "_in_ready"}, int'(in_ready_u), 0);
    checkOutput({tag, "_out_valid_u"}, int'(out_valid_u), 0);
    checkOutput({tag, "_result_u"}, int'(result_u), 0);
    checkOutput({tag, "_out_valid_s"}, int'(out_valid_s), 0);
    checkOutput({tag, "_result_s"}, int'(result_s), 0);
  endtask

  task automatic pulseReinit();
    reinit = 1'b1;
    @(posedge clk);
    #1;
    reinit = 1'b0;
    exp_u.delete();
    exp_s.delete();
    checkOutput("reinit_out_valid_u", int'(out_valid_u), 0);
    checkOutput("reinit_out_valid_s", int'(out_valid_s), 0);
    checkOutput("reinit_init_done", int'(init_done_u), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    reinit = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    #2;
    checkResetOutputs("reset");
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    waitInit("init");

    // directed unsigned: latency and hold after drain
    applyStimulus(7, 7);
    checkOutput("lat_not_yet", int'(out_valid_u), 0);
    @(posedge clk);
    #1;
    checkOutput("lat_valid", int'(out_valid_u), 1);
    checkOutput("lat_result", int'(result_u), 49);
    @(posedge clk);
    #1;
    checkOutput("drain_valid", int'(out_valid_u), 0);
    checkOutput("drain_hold", int'(result_u), 49);
    applyStimulus(0, 5);
    repeat (3) @(posedge clk);
    #1;

    // directed signed corner products
    applyStimulus(5, 3);
    applyStimulus(4, 4);
    applyStimulus(3, 4);
    repeat (4) @(posedge clk);
    #1;

    // full table sweep back-to-back
    gap_mode = 1;
    for (int i = 0; i < DEPTH; i++) applyStimulus(i / (1 << W), i % (1 << W));
    repeat (4) @(posedge clk);
    #1;
    gap_mode = 0;
    checkOutput("stream_count", n_out, DEPTH);
    checkOutput("stream_span", last_out - first_out, DEPTH - 1);

    // stall: result held, input blocked, nothing lost
    applyStimulus(6, 7);
    applyStimulus(3, 5);
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 3'd2;
    b = 3'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", int'(in_ready_u), 0);
      checkOutput("stall_valid", int'(out_valid_u), 1);
      checkOutput("stall_result", int'(result_u), 42);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(2, 2);
    repeat (4) @(posedge clk);
    #1;

    // randomized traffic with random back-pressure
    rnd_bp = 1;
    for (int k = 0; k < 150; k++) begin
      applyStimulus($urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_bp = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rand_drain_u", exp_u.size(), 0);
    checkOutput("rand_drain_s", exp_s.size(), 0);

    // reinit with a full pipeline
    applyStimulus(5, 3);
    applyStimulus(6, 2);
    applyStimulus(7, 3);
    applyStimulus(2, 5);
    applyStimulus(4, 4);
    pulseReinit();
    waitInit("reinit");

    // async reset in the middle of a rebuild
    pulseReinit();
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midinit_reset");
    exp_u.delete();
    exp_s.delete();
    #2;
    rst_n = 1'b1;
    waitInit("rebuild");

    for (int k = 0; k < 12; k++) applyStimulus($urandom_range(0, 7), $urandom_range(0, 7));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("final_drain_u", exp_u.size(), 0);
    checkOutput("final_drain_s", exp_s.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
